readout_sequencer: RTL
======================

# readout_sequencer

Shot-level controller for the IQ integrator in the qubit readout chain. Accepts a burst request (shot count, integration length, repetition gap), sequences the integrator through one reset/start/collect cycle per shot, and hands each integrated I/Q pair downstream on a valid/ready port tagged with its shot index. Sits between the host/command layer and the integrator, replacing the hard-tied `start` and `reset` lines used today.

## Interface
- `SHOT_W`, 16, width of shot count and shot index
- `GAP_W`, 16, width of repetition-gap counter
- `DATA_W`, 32, width of integrated I/Q values
- `TIMEOUT_CYC`, 4096, integration watchdog limit in cycles (used only with the macro)

Ports:
- `clk100`  in  1  100 MHz system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `go`  in  1  burst request; accepted only in IDLE
- `abort`  in  1  cancels the burst from any non-IDLE state
- `num_shots`  in  SHOT_W  shots per burst, latched on accepted `go`
- `sample_length`  in  11  integration length, latched on accepted `go`
- `rep_gap`  in  GAP_W  idle cycles between shots, latched on accepted `go`
- `integ_reset`  out  1  synchronous active-high reset to the integrator
- `integ_start`  out  1  integrator start/enable
- `integ_sample_length`  out  11  latched `sample_length`
- `iq_valid`  in  1  integrator result strobe
- `i_val`, `q_val`  in  DATA_W  integrator results
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream accept
- `res_i`, `res_q`  out  DATA_W  captured results
- `res_idx`  out  SHOT_W  0-based shot index
- `res_err`  out  1  watchdog-expired result
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, ARM, INTEG, OUT, GAP, DONE.
- IDLE: on `go` (and not `abort`), latch config, clear shot index. Next state is ARM, or DONE if `num_shots == 0`.
- ARM: one cycle with `integ_reset = 1`. Next state is INTEG.
- INTEG: `integ_start = 1` is held. On `iq_valid`, capture `i_val`/`q_val` and go to OUT. `iq_valid` is ignored in all other states.
- OUT: `res_valid = 1`. Data and index stay stable until `res_ready`. On accept:
  - if index == `num_shots - 1`: go to DONE
  - else: increment index and go to GAP (or directly to ARM if `rep_gap == 0`)
- GAP: counts `rep_gap` cycles, then goes to ARM.
- DONE: `done = 1` for one cycle, then IDLE.
- `abort` in any non-IDLE state:
  - next state IDLE with `integ_reset = 1` for that cycle
  - `res_valid` and `integ_start` drop
  - no `done` pulse
- `abort` in IDLE has no effect. `go` while busy is ignored. When `go` and `abort` arrive together in IDLE, `abort` wins and the request is dropped.
- Reset values: all outputs 0, state IDLE, latched config 0.
- Counters are unsigned. The shot index never wraps, because the burst ends at `num_shots - 1`.

## Timing
- `go` at cycle 0: `busy` and `integ_reset` high at cycle 1; `integ_start` high from cycle 2.
- `iq_valid` at cycle k: `integ_start` low and `res_valid` high at k+1.
- Accept at cycle m with gap G > 0: GAP for cycles m+1 to m+G, ARM at m+G+1, `integ_start` at m+G+2. With G = 0, ARM is at m+1.
- Final accept at m: `done` at m+1; IDLE at m+2.
- `num_shots = 0`: `done` at cycle 1, no integrator activity.
- All outputs are registered.

## Configuration
- `READOUT_TIMEOUT_EN` defined: an INTEG-state counter runs. After `TIMEOUT_CYC` cycles without `iq_valid`, the block moves to OUT with `res_i = res_q = 0` and `res_err = 1`. The shot counts as delivered and the burst continues.
- Not defined: INTEG waits indefinitely, there is no counter logic, and `res_err` is tied to 0.

## Structure
- Package `readout_pkg`: state enum, default widths (`SHOT_W`, `GAP_W`, `DATA_W`), and `SAMPLE_LEN_W = 11`.
- Single module, no sub-modules. The GAP and timeout counters are inline.

## Test plan
- Normal burst: `num_shots=3`, `sample_length=2000`, `rep_gap=4`, `res_ready=1`; integrator model pulses `iq_valid` 10 cycles after start with `i_val = 100 + idx`, `q_val = 200 + idx`.
  - Expect three results: idx 0/1/2, values 100/101/102 and 200/201/202.
  - Exactly three `integ_reset` pulses, 4 gap cycles between shots, `done` one cycle after the third accept.
- Backpressure: `res_ready` held low for 20 cycles with `res_valid` high. Expect `res_i`/`res_q`/`res_idx` stable and no `integ_start` until accept.
- Zero shots: `go` with `num_shots=0`. Expect `done` and `busy` at cycle 1 only, with `integ_start` and `res_valid` never asserted.
- Abort in INTEG at shot 1 of 3. Expect IDLE next cycle with an `integ_reset` pulse, no `res_valid`, and no `done`. A new `go` then runs a full burst normally.
- Request collisions:
  - `go` during OUT is ignored: the shot count is unchanged.
  - `go` and `abort` together in IDLE: stays IDLE, `busy` stays 0.
- With `READOUT_TIMEOUT_EN` and `TIMEOUT_CYC=64`, no `iq_valid`: `res_valid=1` with `res_err=1` and zero data 65 cycles after `integ_start` rises; the burst proceeds to the next shot.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and default widths for the qubit readout shot sequencer.
package readout_pkg;

   localparam int SHOT_W       = 16;
   localparam int GAP_W        = 16;
   localparam int DATA_W       = 32;
   localparam int SAMPLE_LEN_W = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_INTEG,
      ST_OUT,
      ST_GAP,
      ST_DONE
   } state_e;

endpackage

// File: rtl/readout_sequencer.sv
// Shot-level controller that drives the IQ integrator through reset/start/collect per shot.
// Optional integration watchdog enabled by defining READOUT_TIMEOUT_EN.
module readout_sequencer
   import readout_pkg::*;
#(
   parameter int SHOT_W      = readout_pkg::SHOT_W,
   parameter int GAP_W       = readout_pkg::GAP_W,
   parameter int DATA_W      = readout_pkg::DATA_W,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                    clk100,
   input  logic                    reset_n,
   input  logic                    go,
   input  logic                    abort,
   input  logic [SHOT_W-1:0]       num_shots,
   input  logic [SAMPLE_LEN_W-1:0] sample_length,
   input  logic [GAP_W-1:0]        rep_gap,
   output logic                    integ_reset,
   output logic                    integ_start,
   output logic [SAMPLE_LEN_W-1:0] integ_sample_length,
   input  logic                    iq_valid,
   input  logic [DATA_W-1:0]       i_val,
   input  logic [DATA_W-1:0]       q_val,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [DATA_W-1:0]       res_i,
   output logic [DATA_W-1:0]       res_q,
   output logic [SHOT_W-1:0]       res_idx,
   output logic                    res_err,
   output logic                    busy,
   output logic                    done
);

   if (TIMEOUT_CYC < 1) begin : g_cfg_check
      $error("readout_sequencer: TIMEOUT_CYC must be at least 1");
   end

   state_e                  state_q, state_d;
   logic [SHOT_W-1:0]       nshots_q;
   logic [SHOT_W-1:0]       idx_q;
   logic [SAMPLE_LEN_W-1:0] slen_q;
   logic [GAP_W-1:0]        gap_q;
   logic [GAP_W-1:0]        gap_cnt_q;
   logic [DATA_W-1:0]       res_i_q, res_qv_q;
   logic                    integ_reset_q, integ_start_q, res_valid_q, busy_q, done_q;
   logic                    accept_go, abort_hit, last_shot, timeout_hit;

   assign accept_go = (state_q == ST_IDLE) && go && !abort;
   assign abort_hit = (state_q != ST_IDLE) && abort;
   assign last_shot = (idx_q == nshots_q - SHOT_W'(1));

`ifdef READOUT_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q;
   logic             res_err_q;

   assign timeout_hit = (tmo_q == TMO_W'(TIMEOUT_CYC));
   assign res_err     = res_err_q;

   // Counter is zero on the first INTEG cycle, so the watchdog fires after TIMEOUT_CYC full cycles.
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q     <= '0;
         res_err_q <= 1'b0;
      end else begin
         if (state_q != ST_INTEG) tmo_q <= '0;
         else                     tmo_q <= tmo_q + TMO_W'(1);
         if (state_q == ST_INTEG && state_d == ST_OUT) res_err_q <= !iq_valid;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign res_err     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept_go) state_d = (num_shots == '0) ? ST_DONE : ST_ARM;
         ST_ARM:   state_d = ST_INTEG;
         ST_INTEG: if (iq_valid || timeout_hit) state_d = ST_OUT;
         ST_OUT: begin
            if (res_ready) begin
               if (last_shot)          state_d = ST_DONE;
               else if (gap_q == '0)   state_d = ST_ARM;
               else                    state_d = ST_GAP;
            end
         end
         ST_GAP:   if (gap_cnt_q == '0) state_d = ST_ARM;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort_hit) state_d = ST_IDLE;
   end

   // Outputs are decoded from the next state and registered, so they line up with the state register.
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         nshots_q      <= '0;
         slen_q        <= '0;
         gap_q         <= '0;
         idx_q         <= '0;
         gap_cnt_q     <= '0;
         res_i_q       <= '0;
         res_qv_q      <= '0;
         integ_reset_q <= 1'b0;
         integ_start_q <= 1'b0;
         res_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         integ_reset_q <= (state_d == ST_ARM) || abort_hit;
         integ_start_q <= (state_d == ST_INTEG);
         res_valid_q   <= (state_d == ST_OUT);
         busy_q        <= (state_d != ST_IDLE);
         done_q        <= (state_d == ST_DONE);

         if (accept_go) begin
            nshots_q <= num_shots;
            slen_q   <= sample_length;
            gap_q    <= rep_gap;
            idx_q    <= '0;
         end

         if (state_q == ST_OUT && (state_d == ST_GAP || state_d == ST_ARM))
            idx_q <= idx_q + SHOT_W'(1);

         if (state_q == ST_OUT && state_d == ST_GAP) gap_cnt_q <= gap_q - GAP_W'(1);
         else if (state_q == ST_GAP)                 gap_cnt_q <= gap_cnt_q - GAP_W'(1);

         // A watchdog exit delivers a zeroed result; a real strobe always wins.
         if (state_q == ST_INTEG && state_d == ST_OUT) begin
            if (iq_valid) begin
               res_i_q  <= i_val;
               res_qv_q <= q_val;
            end else begin
               res_i_q  <= '0;
               res_qv_q <= '0;
            end
         end
      end
   end

   assign integ_reset         = integ_reset_q;
   assign integ_start         = integ_start_q;
   assign integ_sample_length = slen_q;
   assign res_valid           = res_valid_q;
   assign res_i               = res_i_q;
   assign res_q               = res_qv_q;
   assign res_idx             = idx_q;
   assign busy                = busy_q;
   assign done                = done_q;

endmodule
